// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer of an async FIFO.
// Drains the FIFO read port into a 2-entry buffer (head/tail) and presents
// the words as a valid/ready stream. rinc depends only on registered state,
// the FIFO empty flag, flush and reset, so m_ready never reaches rinc
// combinationally. Counts delivered words; flush discards buffered words.
// Optional macro FIFO_RD_PARITY_EN adds m_parity, the XOR reduction of
// m_data, stored per buffer entry.

module fifo_rd_stream #(
    parameter int data_bits = 8,
    parameter int CNT_BITS  = 16
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rempty,
    input  logic [data_bits-1:0] rdata,
    output logic                 rinc,
    output logic [data_bits-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic                 flush,
    output logic [CNT_BITS-1:0]  rd_count,
    output logic                 busy
`ifdef FIFO_RD_PARITY_EN
    ,
    output logic                 m_parity
`endif
);

    // Buffer occupancy
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [data_bits-1:0] head_q, head_d;
    logic [data_bits-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 pop;
    logic                 deliver;

`ifdef FIFO_RD_PARITY_EN
    logic                 head_par_q, head_par_d;
    logic                 tail_par_q, tail_par_d;
    logic                 rdata_par;

    assign rdata_par = ^rdata;
`endif

    // Pop only from registered state; reset gates it combinationally
    assign rinc    = !rrst && !rempty && !flush && (state_q != S_TWO);
    assign pop     = rinc;
    assign m_valid = (state_q != S_EMPTY);
    assign deliver = m_valid && m_ready && !flush;

    assign m_data   = head_q;
    assign busy     = m_valid;
    assign rd_count = cnt_q;
`ifdef FIFO_RD_PARITY_EN
    assign m_parity = head_par_q;
`endif

    // Next-state and data movement for the 2-entry buffer
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
`ifdef FIFO_RD_PARITY_EN
        head_par_d = head_par_q;
        tail_par_d = tail_par_q;
`endif
        if (deliver) cnt_d = cnt_q + CNT_BITS'(1);

        case (state_q)
            S_EMPTY: begin
                if (pop) begin
                    state_d = S_ONE;
                    head_d  = rdata;
`ifdef FIFO_RD_PARITY_EN
                    head_par_d = rdata_par;
`endif
                end
            end
            S_ONE: begin
                if (pop && deliver) begin
                    head_d = rdata;
`ifdef FIFO_RD_PARITY_EN
                    head_par_d = rdata_par;
`endif
                end else if (pop) begin
                    state_d = S_TWO;
                    tail_d  = rdata;
`ifdef FIFO_RD_PARITY_EN
                    tail_par_d = rdata_par;
`endif
                end else if (deliver) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                // No pop can happen here; tail slides into head
                if (deliver) begin
                    state_d = S_ONE;
                    head_d  = tail_q;
`ifdef FIFO_RD_PARITY_EN
                    head_par_d = tail_par_q;
`endif
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Flush wins over pop and deliver; FIFO contents stay untouched
        if (flush) begin
            state_d = S_EMPTY;
`ifdef FIFO_RD_PARITY_EN
            head_par_d = 1'b0;
            tail_par_d = 1'b0;
`endif
        end
    end

    // State, data and counter registers
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FIFO_RD_PARITY_EN
    // Parity bits travel with their words
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            head_par_q <= 1'b0;
            tail_par_q <= 1'b0;
        end else begin
            head_par_q <= head_par_d;
            tail_par_q <= tail_par_d;
        end
    end
`endif

endmodule
